sha256_msg_feeder: RTL and testbench

Message front-end for the `sha256` compression core. It accepts a byte stream with a valid/ready handshake and applies SHA-256 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. It assembles 512-bit blocks, drives the core's `start`/`block` interface, waits for `finish` on each block, and presents the final 256-bit digest. Before each new message it clears the core's chaining state by pulsing the core's reset.

---
 rtl/sha256_msg_feeder.sv | 186 ++++++++++++++++++
 tb/tb_sha256_msg_feeder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_feeder.sv
// SHA-256 message front-end: pads a byte stream into 512-bit blocks and sequences the core.
// Optional length saturation/error flag enabled by defining SHA256_FEED_LEN_CHECK_EN.
module sha256_msg_feeder #(
  parameter int unsigned MAX_BYTES_W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         core_reset_n,
  output logic         core_start,
  output logic [511:0] core_block,
  input  logic         core_finish,
  input  logic [255:0] core_digest,
  output logic [255:0] digest,
  output logic         digest_valid
`ifdef SHA256_FEED_LEN_CHECK_EN
  ,
  output logic         len_err
`endif
);

  typedef enum logic [2:0] {StClear, StFill, StPad, StIssue, StWait, StDone} state_e;

  state_e                 state_q, state_d;
  logic [511:0]           block_q, block_d;
  logic [6:0]             off_q, off_d;
  logic [MAX_BYTES_W-1:0] cnt_q, cnt_d;
  logic                   need_marker_q, need_marker_d;
  logic                   need_len_q, need_len_d;
  logic                   final_q, final_d;
  logic                   in_ready_q, core_start_q, core_reset_n_q;
  logic [255:0]           digest_q, digest_d;
  logic                   digest_valid_q, digest_valid_d;
`ifdef SHA256_FEED_LEN_CHECK_EN
  logic                   len_err_q, len_err_d;
`endif

  logic [8:0]  byte_base;
  logic [6:0]  pad_off;
  logic [63:0] bit_len;

  // Byte k of the block sits at bits [8*(63-k) +: 8]; 63-k equals ~k for 6-bit k.
  assign byte_base = {~off_q[5:0], 3'b000};
  assign bit_len   = 64'(cnt_q) << 3;

  always_comb begin
    state_d        = state_q;
    block_d        = block_q;
    off_d          = off_q;
    cnt_d          = cnt_q;
    need_marker_d  = need_marker_q;
    need_len_d     = need_len_q;
    final_d        = final_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    pad_off        = off_q;
`ifdef SHA256_FEED_LEN_CHECK_EN
    len_err_d      = len_err_q;
`endif

    unique case (state_q)
      StClear: begin
        block_d       = '0;
        off_d         = '0;
        cnt_d         = '0;
        need_marker_d = 1'b0;
        need_len_d    = 1'b0;
        final_d       = 1'b0;
`ifdef SHA256_FEED_LEN_CHECK_EN
        len_err_d     = 1'b0;
`endif
        state_d       = StFill;
      end
      StFill: begin
        if (in_valid && in_ready_q) begin
          block_d[byte_base +: 8] = in_data;
          off_d = off_q + 7'd1;
`ifdef SHA256_FEED_LEN_CHECK_EN
          if (cnt_q == {MAX_BYTES_W{1'b1}}) begin
            len_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + MAX_BYTES_W'(1);
          end
`else
          cnt_d = cnt_q + MAX_BYTES_W'(1);
`endif
          if (in_last) begin
            need_marker_d = 1'b1;
            need_len_d    = 1'b1;
            state_d       = (off_d < 7'd64) ? StPad : StIssue;
          end else if (off_d == 7'd64) begin
            state_d = StIssue;
          end
        end
      end
      StPad: begin
        if (need_marker_q) begin
          block_d[byte_base +: 8] = 8'h80;
          pad_off       = off_q + 7'd1;
          need_marker_d = 1'b0;
        end
        off_d = pad_off;
        // The length only fits if the marker left the last 8 bytes free.
        if (need_len_q && (pad_off <= 7'd56)) begin
          block_d[63:0] = bit_len;
          need_len_d    = 1'b0;
          final_d       = 1'b1;
        end
        state_d = StIssue;
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (core_finish) begin
          if (final_q) begin
            digest_d       = core_digest;
            digest_valid_d = 1'b1;
            state_d        = StDone;
          end else begin
            block_d = '0;
            off_d   = '0;
            state_d = (need_marker_q || need_len_q) ? StPad : StFill;
          end
        end
      end
      StDone: begin
        state_d = StClear;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= StClear;
      block_q        <= '0;
      off_q          <= '0;
      cnt_q          <= '0;
      need_marker_q  <= 1'b0;
      need_len_q     <= 1'b0;
      final_q        <= 1'b0;
      in_ready_q     <= 1'b0;
      core_start_q   <= 1'b0;
      core_reset_n_q <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
`ifdef SHA256_FEED_LEN_CHECK_EN
      len_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      block_q        <= block_d;
      off_q          <= off_d;
      cnt_q          <= cnt_d;
      need_marker_q  <= need_marker_d;
      need_len_q     <= need_len_d;
      final_q        <= final_d;
      // Handshake outputs are registered from the upcoming state.
      in_ready_q     <= (state_d == StFill);
      core_start_q   <= (state_d == StIssue);
      core_reset_n_q <= (state_d != StClear);
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
`ifdef SHA256_FEED_LEN_CHECK_EN
      len_err_q      <= len_err_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign core_start   = core_start_q;
  assign core_reset_n = core_reset_n_q;
  assign core_block   = block_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;
`ifdef SHA256_FEED_LEN_CHECK_EN
  assign len_err      = len_err_q;
`endif

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: behavioural SHA-256 core plus an independent padding reference.
module tb_sha256_msg_feeder;

`ifdef SHA256_FEED_LEN_CHECK_EN
  localparam int unsigned MW = 4;
  localparam int NV = 2;
`else
  localparam int unsigned MW = 32;
  localparam int NV = 7;
`endif
  localparam longint unsigned MAXC = (64'd1 << MW) - 64'd1;
  localparam int Lat = 20;
  localparam logic [255:0] Iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         core_finish = 1'b0;
  logic [255:0] core_digest;
  logic         in_ready, core_reset_n, core_start, digest_valid;
  logic [511:0] core_block;
  logic [255:0] digest;
`ifdef SHA256_FEED_LEN_CHECK_EN
  logic         len_err;
`endif

  sha256_msg_feeder #(.MAX_BYTES_W(MW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .core_reset_n(core_reset_n),
    .core_start(core_start), .core_block(core_block), .core_finish(core_finish),
    .core_digest(core_digest), .digest(digest), .digest_valid(digest_valid)
`ifdef SHA256_FEED_LEN_CHECK_EN
    , .len_err(len_err)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  int starts = 0, low_cnt = 0, viol = 0, dv_cnt = 0;
  logic [511:0] exp_blk[$];
  logic [255:0] exp_dig[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w[64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Behavioural core: finish stays high until the next start is accepted.
  logic [255:0] core_h;
  logic [511:0] core_blk;
  int           lat = 0;
  always @(posedge clock) begin
    if (!core_reset_n) begin
      core_h <= Iv; core_finish <= 1'b0; lat <= 0;
    end else if (core_start) begin
      core_blk <= core_block; core_finish <= 1'b0; lat <= Lat;
    end else if (lat > 0) begin
      lat <= lat - 1;
      if (lat == 1) begin
        core_h <= compress(core_h, core_blk);
        core_finish <= 1'b1;
      end
    end
  end
  assign core_digest = core_h;

  always @(negedge clock) begin
    if (reset && !core_reset_n) low_cnt++;
    if (in_ready && (core_start || lat > 0)) viol++;
    if (core_start) begin
      starts++;
      if (exp_blk.size() == 0) chk("core_start_unexpected", {511'd0, core_start}, 512'd0);
      else chk("core_block", core_block, exp_blk.pop_front());
    end
    if (digest_valid) begin
      dv_cnt++;
      if (exp_dig.size() == 0) chk("digest_valid_unexpected", {511'd0, digest_valid}, 512'd0);
      else chk("digest", {256'd0, digest}, {256'd0, exp_dig.pop_front()});
    end
  end

  // Reference padding, written from the SHA-256 definition.
  task automatic expect_msg(input byte unsigned m[$]);
    byte unsigned     p[$];
    longint unsigned  c;
    logic [63:0]      bl;
    logic [511:0]     b;
    logic [255:0]     h;
    p = m;
    c = longint'(m.size());
`ifdef SHA256_FEED_LEN_CHECK_EN
    if (c > MAXC) c = MAXC;
`endif
    bl = 64'(c << 3);
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
    h = Iv;
    for (int k = 0; k < p.size() / 64; k++) begin
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
      exp_blk.push_back(b);
      h = compress(h, b);
    end
    exp_dig.push_back(h);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int g = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && g < 3000) begin @(negedge clock); g++; end
    chk("in_ready_wait", {511'd0, in_ready}, 512'd1);
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (exp_dig.size() != 0 && g < 5000) begin @(negedge clock); g++; end
    chk("digest_wait", 512'(exp_dig.size()), 512'd0);
  endtask

  task automatic run_vec(input string name, input byte unsigned m[$], input int exp_starts,
                         input logic [255:0] known, input bit has_known);
    int s0, l0, v0, d0;
    s0 = starts; l0 = low_cnt; v0 = viol; d0 = dv_cnt;
    expect_msg(m);
    for (int i = 0; i < m.size(); i++) send_byte(m[i], i == m.size() - 1);
    wait_done();
    repeat (4) @(negedge clock);
    chk({name, "/starts"}, 512'(starts - s0), 512'(exp_starts));
    chk({name, "/core_reset_pulse"}, 512'(low_cnt - l0), 512'd1);
    chk({name, "/in_ready_busy"}, 512'(viol - v0), 512'd0);
    chk({name, "/digest_valid_cnt"}, 512'(dv_cnt - d0), 512'd1);
    chk({name, "/blocks_left"}, 512'(exp_blk.size()), 512'd0);
    if (has_known) chk({name, "/known_digest"}, {256'd0, digest}, {256'd0, known});
  endtask

  typedef struct {
    string        name;
    string        msg;
    int           n;
    logic [7:0]   fillb;
    int           starts;
    logic [255:0] known;
    bit           has_known;
  } vec_t;

  localparam logic [255:0] DigAbc =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] Dig56 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  initial begin
    vec_t         vecs[7];
    byte unsigned m[$];
    int           s0, d0, g;

    vecs[0] = '{"abc", "abc", 0, 8'h00, 1, DigAbc, 1'b1};
    vecs[1] = '{"one_byte", "", 1, 8'h7e, 1, '0, 1'b0};
    vecs[2] = '{"abc56", "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 0, 8'h00,
                2, Dig56, 1'b1};
    vecs[3] = '{"zero64", "", 64, 8'h00, 2, '0, 1'b0};
    vecs[4] = '{"a55", "", 55, 8'h61, 1, '0, 1'b0};
    vecs[5] = '{"b57", "", 57, 8'h5a, 2, '0, 1'b0};
    vecs[6] = '{"c63", "", 63, 8'hc3, 2, '0, 1'b0};

    repeat (3) @(negedge clock);
    chk("rst/in_ready", {511'd0, in_ready}, 512'd0);
    chk("rst/core_start", {511'd0, core_start}, 512'd0);
    chk("rst/core_reset_n", {511'd0, core_reset_n}, 512'd0);
    chk("rst/core_block", core_block, 512'd0);
    chk("rst/digest", {256'd0, digest}, 512'd0);
    chk("rst/digest_valid", {511'd0, digest_valid}, 512'd0);
`ifdef SHA256_FEED_LEN_CHECK_EN
    chk("rst/len_err", {511'd0, len_err}, 512'd0);
`endif
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);

    for (int v = 0; v < NV; v++) begin
      m.delete();
      if (vecs[v].msg.len() != 0) begin
        for (int i = 0; i < vecs[v].msg.len(); i++) m.push_back(vecs[v].msg[i]);
      end else begin
        for (int i = 0; i < vecs[v].n; i++) m.push_back(vecs[v].fillb);
      end
      run_vec(vecs[v].name, m, vecs[v].starts, vecs[v].known, vecs[v].has_known);
    end

    // Reset pulse while the core is busy with "abc": the message is dropped.
    m = '{8'h61, 8'h62, 8'h63};
    expect_msg(m);
    s0 = starts; d0 = dv_cnt; g = 0;
    for (int i = 0; i < 3; i++) send_byte(m[i], i == 2);
    while (starts == s0 && g < 500) begin @(negedge clock); g++; end
    chk("rst_mid/started", 512'(starts - s0), 512'd1);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid/core_reset_n", {511'd0, core_reset_n}, 512'd0);
    chk("rst_mid/in_ready", {511'd0, in_ready}, 512'd0);
    reset = 1'b1;
    exp_dig.delete();
    repeat (Lat + 20) @(negedge clock);
    chk("rst_mid/no_digest", 512'(dv_cnt - d0), 512'd0);
    run_vec("abc_after_rst", m, 1, DigAbc, 1'b1);

`ifdef SHA256_FEED_LEN_CHECK_EN
    m.delete();
    for (int i = 0; i < 17; i++) m.push_back(8'h11);
    expect_msg(m);
    for (int i = 0; i < 17; i++) begin
      send_byte(m[i], i == 16);
      if (i == 14) chk("len/before_sat", {511'd0, len_err}, 512'd0);
      if (i == 15) chk("len/after_16", {511'd0, len_err}, 512'd1);
    end
    wait_done();
    repeat (4) @(negedge clock);
    chk("len/cleared", {511'd0, len_err}, 512'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
